// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory stage. Registers ALU results toward the register file
//                and runs byte-serial loads/stores over a 1-cycle read-latency
//                byte bus, stalling EX while an access is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic                      ex_wreg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wd,
  input  logic [31:0]               ex_wdata,
  input  logic                      ex_is_load,
  input  logic                      ex_is_store,
  input  logic [2:0]                ex_funct3,
  input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
  input  logic [31:0]               ex_store_data,
  output logic                      stall_req,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic [ADDR_WIDTH-1:0]     mem_a,
  output logic                      mem_wr,
  output logic [7:0]                mem_dout,
  input  logic [7:0]                mem_din,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [31:0]               wb_wdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;        // bytes already issued
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [31:0]               sdata_q, sdata_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic                      load_q, load_d;
  logic                      wreg_q, wreg_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [31:0]               ldata_q, ldata_d;    // load bytes gathered so far
  logic                      wb_we_q, wb_we_d;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_q, wb_waddr_d;
  logic [31:0]               wb_wdata_q, wb_wdata_d;

  logic                      w_mem_op;
  logic                      w_req_idle;
  logic                      w_access;
  logic [2:0]                w_last;
  logic [1:0]                w_byte_idx;
  logic [31:0]               w_merged;
  logic [31:0]               w_ext;
  logic [31:0]               w_sshift;

  assign w_mem_op   = ex_is_load | ex_is_store;
  assign w_req_idle = !rst && (state_q == S_IDLE) && ex_valid && w_mem_op;
  assign w_access   = !rst && (state_q == S_ACCESS);

  // Bus and stall outputs: requests are raised combinationally while waiting for a grant
  always_comb begin
    stall_req = w_req_idle | (!rst && (state_q != S_IDLE));
    mem_req   = w_req_idle | w_access;
    mem_wr    = w_access & ~load_q;
    mem_a     = w_access ? (addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q}) : '0;
    w_sshift  = sdata_q >> {cnt_q[1:0], 3'b000};
    mem_dout  = (w_access && !load_q) ? w_sshift[7:0] : 8'h00;
  end

  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;

  // Next-state logic: accept in IDLE, issue N bytes, then one extra cycle for the last load byte
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    load_d     = load_q;
    wreg_d     = wreg_q;
    rd_d       = rd_q;
    ldata_d    = ldata_q;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;

    case (size_q)
      2'd0:    w_last = 3'd0;
      2'd1:    w_last = 3'd1;
      default: w_last = 3'd3;
    endcase

    // The byte returned this cycle belongs to the previous issued address
    w_byte_idx = cnt_q[1:0] - 2'd1;
    w_merged   = ldata_q;
    case (w_byte_idx)
      2'd0:    w_merged[7:0]   = mem_din;
      2'd1:    w_merged[15:8]  = mem_din;
      2'd2:    w_merged[23:16] = mem_din;
      default: w_merged[31:24] = mem_din;
    endcase

    case (size_q)
      2'd0:    w_ext = {{24{~uns_q & w_merged[7]}}, w_merged[7:0]};
      2'd1:    w_ext = {{16{~uns_q & w_merged[15]}}, w_merged[15:0]};
      default: w_ext = w_merged;
    endcase

    case (state_q)
      S_IDLE: begin
        if (ex_valid && w_mem_op) begin
          if (mem_gnt) begin
            state_d = S_ACCESS;
            cnt_d   = 3'd0;
            addr_d  = ex_mem_addr;
            sdata_d = ex_store_data;
            size_d  = ex_funct3[1:0];
            uns_d   = ex_funct3[2];
            load_d  = ex_is_load;
            wreg_d  = ex_wreg;
            rd_d    = ex_wd;
            ldata_d = 32'h0;
          end
        end else if (ex_valid) begin
          wb_we_d    = ex_wreg;
          wb_waddr_d = ex_wd;
          wb_wdata_d = ex_wdata;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (load_q && (cnt_q != 3'd0)) begin
          ldata_d = w_merged;
        end
        if (cnt_q == w_last) begin
          state_d = load_q ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        wb_we_d    = wreg_q;
        wb_waddr_d = rd_q;
        wb_wdata_d = w_ext;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      sdata_q    <= 32'h0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      wreg_q     <= 1'b0;
      rd_q       <= '0;
      ldata_q    <= 32'h0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      load_q     <= load_d;
      wreg_q     <= wreg_d;
      rd_q       <= rd_d;
      ldata_q    <= ldata_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu: directed cases with literal
//                expectations, then randomized traffic against a
//                transaction-level model of the memory stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wreg, ex_is_load, ex_is_store;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        stall_req, mem_req, mem_gnt, mem_wr, wb_we;
  logic [31:0] mem_a, wb_wdata;
  logic [7:0]  mem_dout, mem_din;
  logic [4:0]  wb_waddr;

  mem_lsu #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
    .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .stall_req(stall_req), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: one outstanding memory transaction, t = cycles since grant
  bit          m_busy = 1'b0;
  int          m_t, m_n;
  bit          m_load, m_uns, m_wreg;
  logic [4:0]  m_rd;
  logic [31:0] m_addr, m_data;
  logic [7:0]  m_bytes [4];
  logic        e_we = 1'b0;
  logic [4:0]  e_waddr = 5'd0;
  logic [31:0] e_wdata = 32'h0;
  bit          e_full = 1'b0;
  logic [7:0]  sw_bytes [4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        e_stall, e_req, e_wr;
    logic [31:0] e_a;
    logic [7:0]  e_dout;
    if (rst) return;
    e_stall = 1'b0; e_req = 1'b0; e_wr = 1'b0; e_a = 32'h0; e_dout = 8'h0;
    if (!m_busy) begin
      if (ex_valid && (ex_is_load || ex_is_store)) begin
        e_stall = 1'b1;
        e_req   = 1'b1;
      end
    end else if (m_t <= m_n) begin
      e_stall = 1'b1;
      e_req   = 1'b1;
      e_a     = m_addr + 32'(m_t - 1);
      e_wr    = !m_load;
      e_dout  = m_load ? 8'h00 : m_data[8*(m_t-1) +: 8];
    end else begin
      e_stall = 1'b1;
    end
    chk("stall_req", 32'(stall_req), 32'(e_stall));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("mem_a", mem_a, e_a);
    chk("mem_dout", 32'(mem_dout), 32'(e_dout));
    chk("wb_we", 32'(wb_we), 32'(e_we));
    if (e_we || e_full) begin
      chk("wb_waddr", 32'(wb_waddr), 32'(e_waddr));
      chk("wb_wdata", wb_wdata, e_wdata);
    end
  endtask

  task automatic model_update();
    longint v;
    if (rst) begin
      m_busy = 1'b0; e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'h0; e_full = 1'b1;
      return;
    end
    e_we   = 1'b0;
    e_full = 1'b0;
    if (!m_busy) begin
      if (ex_valid && (ex_is_load || ex_is_store)) begin
        if (mem_gnt) begin
          m_busy = 1'b1;
          m_t    = 1;
          m_n    = (ex_funct3[1:0] == 2'd0) ? 1 : (ex_funct3[1:0] == 2'd1) ? 2 : 4;
          m_load = ex_is_load;
          m_uns  = ex_funct3[2];
          m_wreg = ex_wreg;
          m_rd   = ex_wd;
          m_addr = ex_mem_addr;
          m_data = ex_store_data;
        end
      end else if (ex_valid) begin
        e_we = ex_wreg; e_waddr = ex_wd; e_wdata = ex_wdata;
      end
    end else begin
      if (m_load && m_t >= 2) m_bytes[m_t-2] = mem_din;
      if (!m_load && m_t == m_n) begin
        m_busy = 1'b0;
      end else if (m_load && m_t == m_n + 1) begin
        v = 0;
        for (int i = 0; i < m_n; i++) v += longint'(m_bytes[i]) << (8*i);
        if (!m_uns && m_bytes[m_n-1][7]) v -= (longint'(1) << (8*m_n));
        e_we = m_wreg; e_waddr = m_rd; e_wdata = v[31:0];
        m_busy = 1'b0;
      end
      m_t++;
    end
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0; mem_gnt = 1'b0; mem_din = 8'h0;
  endtask

  task automatic mem_in(bit ld, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                        logic [4:0] rd, bit g);
    idle_in();
    ex_valid = 1'b1; ex_wreg = 1'b1; ex_wd = rd; ex_is_load = ld; ex_is_store = !ld;
    ex_funct3 = f3; ex_mem_addr = a; ex_store_data = d; mem_gnt = g;
  endtask

  task automatic settle();
    #3;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kind;
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    rst = 1'b1;
    idle_in();
    #1;
    settle(); advance();
    rst = 1'b0;

    // reset state
    settle();
    chk("rst_wb_we", 32'(wb_we), 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    advance();

    // ALU pass-through
    idle_in(); ex_valid = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5; ex_wdata = 32'h1234;
    settle(); chk("alu_stall", 32'(stall_req), 32'h0); advance();
    idle_in(); settle();
    chk("alu_we", 32'(wb_we), 32'h1);
    chk("alu_waddr", 32'(wb_waddr), 32'd5);
    chk("alu_wdata", wb_wdata, 32'h1234);
    advance();

    // SW 0xDEADBEEF at 0x100
    mem_in(1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd7, 1'b1);
    settle(); chk("sw_stall0", 32'(stall_req), 32'h1); advance();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("sw_wr", 32'(mem_wr), 32'h1);
      chk("sw_a", mem_a, 32'h100 + 32'(k));
      chk("sw_dout", 32'(mem_dout), 32'(sw_bytes[k]));
      chk("sw_stall", 32'(stall_req), 32'h1);
      advance();
    end
    settle();
    chk("sw_done_we", 32'(wb_we), 32'h0);
    chk("sw_done_stall", 32'(stall_req), 32'h0);
    advance();

    // LB / LBU at 0x200 returning 0x80
    for (int u = 0; u < 2; u++) begin
      mem_in(1'b1, (u != 0) ? 3'd4 : 3'd0, 32'h200, 32'h0, 5'd9, 1'b1);
      settle(); advance();
      idle_in(); settle(); chk("lb_a", mem_a, 32'h200); advance();
      mem_din = 8'h80; settle();
      chk("lb_wait_stall", 32'(stall_req), 32'h1);
      chk("lb_wait_req", 32'(mem_req), 32'h0);
      advance();
      mem_din = 8'h00; settle();
      chk("lb_we", 32'(wb_we), 32'h1);
      chk("lb_wdata", wb_wdata, (u != 0) ? 32'h00000080 : 32'hFFFFFF80);
      advance();
    end

    // LH wrapping at the top of the address space
    mem_in(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0, 5'd3, 1'b1);
    settle(); advance();
    idle_in(); settle(); chk("lh_a0", mem_a, 32'hFFFFFFFF); advance();
    mem_din = 8'h34; settle(); chk("lh_a1", mem_a, 32'h0); advance();
    mem_din = 8'h92; settle(); advance();
    mem_din = 8'h00; settle();
    chk("lh_wdata", wb_wdata, 32'hFFFF9234);
    advance();

    // LW waiting three cycles for the grant
    for (int i = 0; i < 3; i++) begin
      mem_in(1'b1, 3'd2, 32'h40, 32'h0, 5'd4, 1'b0);
      settle();
      chk("gnt_stall", 32'(stall_req), 32'h1);
      chk("gnt_req", 32'(mem_req), 32'h1);
      chk("gnt_wr", 32'(mem_wr), 32'h0);
      advance();
    end
    mem_in(1'b1, 3'd2, 32'h40, 32'h0, 5'd4, 1'b1);
    settle(); advance();
    for (int i = 1; i <= 5; i++) begin
      idle_in(); mem_din = 8'($urandom);
      settle(); chk("gnt_no_wb", 32'(wb_we), 32'h0); advance();
    end
    idle_in(); settle(); chk("gnt_wb", 32'(wb_we), 32'h1); advance();

    // reset in the middle of a LW
    mem_in(1'b1, 3'd2, 32'h80, 32'h0, 5'd6, 1'b1);
    settle(); advance();
    idle_in(); settle(); advance();
    rst = 1'b1; settle(); advance();
    rst = 1'b0;
    idle_in(); ex_valid = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd8; ex_wdata = 32'h55;
    settle();
    chk("rst_mid_wr", 32'(mem_wr), 32'h0);
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_we", 32'(wb_we), 32'h0);
    advance();
    idle_in(); settle();
    chk("rst_alu_we", 32'(wb_we), 32'h1);
    chk("rst_alu_wdata", wb_wdata, 32'h55);
    advance();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      rst           = ($urandom_range(0, 199) == 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      kind          = int'($urandom_range(0, 2));
      ex_is_load    = (kind == 1);
      ex_is_store   = (kind == 2);
      ex_wreg       = 1'($urandom);
      ex_wd         = 5'($urandom);
      ex_wdata      = $urandom;
      ex_funct3     = 3'($urandom);
      ex_mem_addr   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                                  : $urandom;
      ex_store_data = $urandom;
      mem_gnt       = ($urandom_range(0, 2) != 0);
      mem_din       = 8'($urandom);
      settle();
      advance();
    end
    rst = 1'b0;
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
